// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a show-ahead byte FIFO.
// Companion to uart_tx; one clock domain, synchronous reset.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_clk,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  input  logic       uart_rx_read,
  output logic       uart_rx_busy,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_overrun
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = PW + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [NW-1:0] N_FULL   = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic          rxd_m;
  logic          rxd_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [NW-1:0] count;

  logic cnt_last;
  logic cnt_half;
  logic full;
  logic pop;
  logic stop_smp;
  logic push;

  assign cnt_last = (cnt == CNT_LAST);
  assign cnt_half = (cnt == CNT_HALF);
  assign full     = (count == N_FULL);
  assign pop      = uart_rx_read && uart_rx_valid;
  assign stop_smp = (state == STOP) && cnt_last;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign push     = stop_smp && rxd_s && (!full || pop);

  assign uart_rx_valid = (count != '0);
  assign uart_rx_data  = uart_rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      state             <= IDLE;
      cnt               <= '0;
      bit_idx           <= '0;
      shift             <= '0;
      uart_rx_busy      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_overrun   <= 1'b0;
    end else begin
      uart_rx_frame_err <= 1'b0;
      uart_rx_overrun   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rxd_s) begin
            state        <= START;
            cnt          <= '0;
            uart_rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt_half) begin
            cnt <= '0;
            if (!rxd_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state        <= IDLE;
              uart_rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_last) begin
            shift   <= {rxd_s, shift[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt <= '0;
            if (rxd_s) begin
              state           <= IDLE;
              uart_rx_busy    <= 1'b0;
              uart_rx_overrun <= !push;
            end else begin
              state             <= BREAK;
              uart_rx_frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Hold here until the line releases so a stuck-low line stays quiet.
          if (rxd_s) begin
            state        <= IDLE;
            uart_rx_busy <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          uart_rx_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a byte scoreboard.
// Inputs and samples both happen on the falling clock edge.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_clk;
  logic       uart_rxd;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_read;
  logic       uart_rx_busy;
  logic       uart_rx_frame_err;
  logic       uart_rx_overrun;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk              (clk),
    .rst_clk          (rst_clk),
    .uart_rxd         (uart_rxd),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_read     (uart_rx_read),
    .uart_rx_busy     (uart_rx_busy),
    .uart_rx_frame_err(uart_rx_frame_err),
    .uart_rx_overrun  (uart_rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int bz_cnt = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (uart_rx_frame_err) fe_cnt++;
    if (uart_rx_overrun) ov_cnt++;
    if (uart_rx_busy) bz_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // mode 0: plain, 1: check push latency, 2: read in stop-sample cycle
  task automatic send(input logic [7:0] b, input logic stopv,
                      input int mode);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stopv;
    repeat (10) @(negedge clk);
    if (mode == 1) begin
      chk("lat_154_valid", 32'(uart_rx_valid), 32'd0);
      @(negedge clk);
      chk("lat_155_valid", 32'(uart_rx_valid), 32'd1);
      chk("lat_155_data", 32'(uart_rx_data), 32'(b));
      repeat (5) @(negedge clk);
    end else if (mode == 2) begin
      chk("full_head", 32'(uart_rx_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      uart_rx_read = 1'b1;
      @(negedge clk);
      uart_rx_read = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    int n;
    n = 0;
    while (!uart_rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(uart_rx_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(uart_rx_data), 32'(e));
    end
    uart_rx_read = 1'b1;
    @(negedge clk);
    uart_rx_read = 1'b0;
  endtask

  initial begin
    int s_fe;
    int s_ov;
    int s_bz;
    rst_clk      = 1'b1;
    uart_rxd     = 1'b1;
    uart_rx_read = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", 32'(uart_rx_valid), 32'd0);
    chk("rst_data", 32'(uart_rx_data), 32'd0);
    chk("rst_busy", 32'(uart_rx_busy), 32'd0);
    chk("rst_fe", 32'(uart_rx_frame_err), 32'd0);
    chk("rst_ov", 32'(uart_rx_overrun), 32'd0);
    rst_clk = 1'b0;
    repeat (5) @(negedge clk);

    exp_q.push_back(8'h42);
    send(8'h42, 1'b1, 1);
    pop_check("single");
    chk("single_empty_valid", 32'(uart_rx_valid), 32'd0);
    chk("single_empty_data", 32'(uart_rx_data), 32'd0);

    s_bz = bz_cnt;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_seen", 32'(bz_cnt > s_bz), 32'd1);
    chk("glitch_busy_end", 32'(uart_rx_busy), 32'd0);
    chk("glitch_no_push", 32'(uart_rx_valid), 32'd0);

    s_fe = fe_cnt;
    send(8'hA5, 1'b0, 0);
    uart_rxd = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("ferr_busy_break", 32'(uart_rx_busy), 32'd1);
    chk("ferr_pulses", 32'(fe_cnt - s_fe), 32'd1);
    chk("ferr_fifo_empty", 32'(uart_rx_valid), 32'd0);
    uart_rxd = 1'b1;
    repeat (6) @(negedge clk);
    chk("ferr_busy_release", 32'(uart_rx_busy), 32'd0);
    repeat (10) @(negedge clk);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, 0);
    pop_check("after_ferr");

    s_ov = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send(8'(i), 1'b1, 0);
    end
    chk("ovr_pulses", 32'(ov_cnt - s_ov), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("ovr_pop");
    chk("ovr_drained", 32'(uart_rx_valid), 32'd0);

    s_ov = ov_cnt;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i), 1'b1, 0);
    end
    exp_q.push_back(8'h05);
    send(8'h05, 1'b1, 2);
    chk("fullpop_no_ovr", 32'(ov_cnt - s_ov), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("fullpop_pop");
    chk("fullpop_drained", 32'(uart_rx_valid), 32'd0);

    send(8'h77, 1'b1, 0);
    chk("rstmid_pre_valid", 32'(uart_rx_valid), 32'd1);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = i[0];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_clk = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", 32'(uart_rx_valid), 32'd0);
    chk("rstmid_data", 32'(uart_rx_data), 32'd0);
    chk("rstmid_busy", 32'(uart_rx_busy), 32'd0);
    chk("rstmid_fe", 32'(uart_rx_frame_err), 32'd0);
    rst_clk = 1'b0;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b1, 0);
    pop_check("rstmid_c3");
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver and companion to the existing `uart_tx`. It samples a single asynchronous serial line using 8N1 framing, LSB first, and checks the start bit and the stop bit. Received bytes go into a small show-ahead FIFO that the top-level FSM drains through a valid/read handshake. The block sits beside `uart_tx` in the top level, fed from a `ui_in` pin.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per bit (10 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4: number of FIFO entries. Power of two, ≥ 2.
- `clk`, input, 1: clock. Single clock domain.
- `rst_clk`, input, 1: reset. Synchronous, active-high.
- `uart_rxd`, input, 1: asynchronous serial line. Idles high.
- `uart_rx_data`, output, 8: FIFO head byte. Reads 8'h00 when the FIFO is empty.
- `uart_rx_valid`, output, 1: FIFO not empty.
- `uart_rx_read`, input, 1: pop the head. Effective only while `uart_rx_valid` = 1.
- `uart_rx_busy`, output, 1: a frame is in progress (state ≠ IDLE).
- `uart_rx_frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `uart_rx_overrun`, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Reset.** While `rst_clk` = 1:
  - Both synchronizer flops are set to 1.
  - State = IDLE; bit counter, cycle counter and shift register = 0.
  - FIFO is emptied.
  - All outputs are 0 (`uart_rx_data` = 8'h00).
- **Synchronizer.** `uart_rxd` passes through two flops; the second is `rxd_s`. All decisions use `rxd_s` only.
- **Counters.** HALF = CLKS_PER_BIT/2 (integer division). The cycle counter `cnt` is sized for CLKS_PER_BIT−1 and increments every cycle in START, DATA and STOP.
- **IDLE.** If `rxd_s` = 0, go to START with `cnt` = 0.
- **START.** When `cnt` = HALF−1, sample `rxd_s`:
  - 0: go to DATA with `cnt` = 0 and `bit_idx` = 0.
  - 1: glitch. Return to IDLE with no outputs.
- **DATA.** When `cnt` = CLKS_PER_BIT−1:
  - Shift right, inserting `rxd_s` at bit 7; clear `cnt`; increment `bit_idx`.
  - After the 8th bit, go to STOP.
- **STOP.** When `cnt` = CLKS_PER_BIT−1, sample `rxd_s`:
  - 1 and FIFO has space (after any same-cycle pop): push the byte, go to IDLE.
  - 1 and FIFO full with no pop: drop the byte, pulse `uart_rx_overrun`, go to IDLE.
  - 0: drop the byte, pulse `uart_rx_frame_err`, go to BREAK.
- **BREAK.** Wait for `rxd_s` = 1, then go to IDLE. This prevents a held-low line from re-triggering.
- **FIFO.** Circular buffer with read/write pointers and an occupancy count of clog2(FIFO_DEPTH)+1 bits.
  - Pop when `uart_rx_read` && `uart_rx_valid`. A read while empty is ignored.
  - Push and pop in the same cycle leave the count unchanged. This holds even when full: the push is accepted and no overrun is raised.
  - Pointers wrap modulo FIFO_DEPTH.
- **Priority.** `rst_clk` overrides everything. Reset mid-frame aborts the frame with no pulse. The next falling edge after reset starts a clean frame.

## Timing
- Let E0 be the edge at which IDLE sees `rxd_s` = 0. `rxd_s` lags `uart_rxd` by 2 edges.
- Start-bit check happens at E0+HALF.
- Data bit i (0..7) is sampled at E0+HALF+(i+1)·CLKS_PER_BIT.
- The stop bit is sampled at E0+HALF+9·CLKS_PER_BIT.
- On a successful push, `uart_rx_valid` and `uart_rx_data` update the cycle after the stop sample. With default parameters that is 826 cycles after E0.
- `uart_rx_frame_err` and `uart_rx_overrun` are high for exactly the one cycle after the stop sample.
- `uart_rx_busy` rises the cycle after E0 and falls the cycle after leaving STOP (or after leaving BREAK).
- Pop latency: `uart_rx_data` and `uart_rx_valid` show the next entry the cycle after the read edge.
- Back-to-back frames: a new start bit may begin immediately after the stop sample. IDLE accepts it on the next cycle.

## Test plan
Use CLKS_PER_BIT = 16 and FIFO_DEPTH = 4 unless noted.
- **Single byte.** Drive 8N1 frame 0x42 → `uart_rx_valid` = 1 and `uart_rx_data` = 0x42, 2+8+144+1 cycles after the line falls. Then pulse read → valid = 0, data = 0x00.
- **Glitch.** Drive `uart_rxd` low for 4 cycles, then high → no push; `uart_rx_busy` pulses then returns to 0.
- **Framing error.**
  - Drive 0xA5 with stop bit 0, then hold low for 3 bit-times → one `uart_rx_frame_err` pulse, FIFO empty, busy held through BREAK.
  - Release the line, then send 0x5A → 0x5A received.
- **Overrun.** Send 0x01..0x05 with no reads → one `uart_rx_overrun` pulse on the 5th frame. Reads then return 01, 02, 03, 04, then valid = 0.
- **Full plus simultaneous pop.** Fill with 01..04, assert read in the stop-sample cycle of 0x05 → no overrun; FIFO holds 02, 03, 04, 05.
- **Reset mid-frame.** Assert `rst_clk` during DATA bit 3 → all outputs 0 on the next cycle. A following frame 0xC3 is received correctly.
